led_sequencer: RTL and testbench
================================

# led_sequencer

Parametrised LED pattern sequencer driving the board LED bank from the 100 MHz system clock. Generalises the fixed single-LED rotator: configurable LED count and step period, four run-time selectable patterns, run/pause control with single-step, and a step strobe for other logic. It sits at top level between the clock/reset inputs and the `leds` pins.

## Interface
- `NUM_LEDS`, 16: LED count, ≥1.
- `TICKS_PER_STEP`, 50_000_000: clock cycles per pattern step, ≥1.
- `clk100m` in, 1: system clock, 100 MHz.
- `rst` in, 1: reset, asynchronous, active-high.
- `mode` in, 2: pattern select. 0 = rotate left, 1 = rotate right, 2 = bounce, 3 = binary count.
- `enable` in, 1: 1 = free-run, 0 = paused.
- `step` in, 1: single-step request, honoured only while `enable` = 0.
- `leds` out, NUM_LEDS: pattern output, registered.
- `tick` out, 1: one-cycle pulse in the cycle `leds` takes a new step value.

## Operation
- Reset values:
  - `leds` = 1 (bit 0 lit).
  - `tick` = 0.
  - Divider counter = 0.
  - Bounce direction = left.
  - Registered mode copy = 0.
- Divider:
  - Counts 0..TICKS_PER_STEP−1 only while `enable` = 1.
  - Generates an internal advance at count TICKS_PER_STEP−1, then wraps to 0.
  - While paused, the counter holds its value and does not clear.
- Advance source:
  - Divider terminal count when `enable` = 1.
  - `step` = 1 when `enable` = 0; one advance per cycle `step` is high, no edge detection.
- Patterns, on each advance:
  - Rotate left: `leds` <= {leds[N−2:0], leds[N−1]}.
  - Rotate right: `leds` <= {leds[0], leds[N−1:1]}.
  - Bounce: single lit bit moves in the current direction. Direction flips when the lit bit reaches bit N−1 (going left) or bit 0 (going right). That end bit is shown for exactly one step, and the next advance moves away from it.
  - Binary count: `leds` <= leds + 1, modulo 2^N. All-ones wraps to 0.
- Mode change:
  - Triggered when `mode` differs from its registered copy.
  - Next edge loads the seed: 1 for modes 0–2, 0 for mode 3.
  - Same edge clears the divider and sets direction = left.
  - No `tick` is generated.
  - Mode change has priority over any advance in the same cycle.
- Pattern state:
  - Rotate and bounce keep exactly one lit bit at all times.
  - An illegal pattern state cannot arise after reset.
- `NUM_LEDS` = 1:
  - Rotate and bounce hold `leds` = 1.
  - Count toggles bit 0.
  - `tick` still pulses on every advance.

## Timing
- Free-run: `tick` pulses every TICKS_PER_STEP cycles. With TICKS_PER_STEP = 1, `tick` is high every cycle while enabled.
- First advance after reset or mode change occurs TICKS_PER_STEP cycles after the first enabled cycle.
- Step latency: `step` sampled high at edge k means `leds` updated and `tick` = 1 after edge k.
- `enable` 1→0 freezes at the current count. 0→1 resumes from the held count; remaining cycles are not lost.
- Asynchronous `rst` assertion mid-step forces reset values immediately, with no waiting for a clock edge. Operation restarts from count 0 on the first edge after deassertion.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `led_seq_pkg`:
  - Mode encoding constants `MODE_ROT_L`, `MODE_ROT_R`, `MODE_BOUNCE`, `MODE_COUNT`.
  - Seed constants.
- Divider width: localparam `$clog2(TICKS_PER_STEP)`, minimum 1.
- Sub-module `tick_divider`:
  - Ports: `clk100m`, `rst`, `en`, `clr`, `tick`.
  - Parameter: `TICKS_PER_STEP`.
  - Reusable elsewhere in the design for slow strobes.
- Pattern logic lives in `led_sequencer`.

## Test plan
All scenarios use NUM_LEDS = 4 and TICKS_PER_STEP = 4 unless stated.
1. Reset, `mode` = 0, `enable` = 1, run 20 cycles → `leds` 0001 → 0010 → 0100 → 1000 → 0001. `tick` pulses every 4th cycle, 5 pulses total.
2. `mode` = 2, `enable` = 1, 8 steps → `leds` 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
3. `mode` = 3 from reset, 17 steps → `leds` counts 0..15, then wraps to 0000 with a `tick` on the wrap.
4. `enable` = 0 after 2 cycles of the divider, 10 idle cycles, then `enable` = 1 → no `tick` while paused; first `tick` exactly 2 enabled cycles after resume.
5. `enable` = 0, `step` high 3 consecutive cycles in mode 1 → `leds` 1000, 0100, 0010, each one cycle after its `step` sample. `step` with `enable` = 1 has no effect beyond normal ticks.
6. Switch `mode` 0→3 in the cycle the divider is at terminal count → `leds` = 0000, no `tick`, and the next `tick` 4 cycles later with `leds` = 0001. Then assert `rst` mid-count → `leds` = 0001 asynchronously.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, seeds, control payload.
package led_seq_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ROT_L  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ROT_R  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;
  localparam logic [MODE_W-1:0] MODE_COUNT  = 2'd3;

  // Seeds are single-bit values zero-extended to the LED width.
  localparam logic SEED_PATTERN = 1'b1;
  localparam logic SEED_COUNT   = 1'b0;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              enable;
    logic              step;
  } led_seq_ctrl_t;

  function automatic logic seed_bit(input logic [MODE_W-1:0] mode);
    return (mode == MODE_COUNT) ? SEED_COUNT : SEED_PATTERN;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Control/LED bundle between the sequencer and whatever drives it.
interface led_sequencer_if #(
  parameter int unsigned NUM_LEDS = 16
);
  import led_seq_pkg::*;

  led_seq_ctrl_t       ctrl;
  logic [NUM_LEDS-1:0] leds;
  logic                tick;

  modport master (output ctrl, input leds, input tick);
  modport slave  (input ctrl, output leds, output tick);

endinterface

// File: rtl/led_sequencer_tick_divider.sv
// Free-running step divider: strobes at terminal count while enabled, holds when paused.
module tick_divider #(
  parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
  input  logic clk100m,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_STEP - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             term_c;

  assign term_c = (cnt_q == TERM);
  // A clear in the same cycle swallows the strobe so callers see a clean restart.
  assign tick   = en & term_c & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate/bounce/count patterns advanced by a divider or single-step.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 16,
  parameter int unsigned TICKS_PER_STEP = 50_000_000
) (
  input  logic                  clk100m,
  input  logic                  rst,
  led_sequencer_if.slave        bus
);

  localparam int unsigned LW = NUM_LEDS;

  logic [LW-1:0]     leds_q;
  logic [LW-1:0]     leds_d;
  logic              tick_q;
  logic              tick_d;
  logic              dir_q;
  logic              dir_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;

  logic              mode_chg_c;
  logic              div_tick_c;
  logic              advance_c;

  assign mode_chg_c = (bus.ctrl.mode != mode_q);

  tick_divider #(
    .TICKS_PER_STEP (TICKS_PER_STEP)
  ) u_tick_divider (
    .clk100m (clk100m),
    .rst     (rst),
    .en      (bus.ctrl.enable),
    .clr     (mode_chg_c),
    .tick    (div_tick_c)
  );

  // Single-step only counts while paused; free-run ignores it.
  assign advance_c = bus.ctrl.enable ? div_tick_c : bus.ctrl.step;

  always_comb begin
    leds_d = leds_q;
    tick_d = 1'b0;
    dir_d  = dir_q;
    mode_d = bus.ctrl.mode;
    if (mode_chg_c) begin
      leds_d = LW'(seed_bit(bus.ctrl.mode));
      dir_d  = DIR_LEFT;
    end else if (advance_c) begin
      tick_d = 1'b1;
      case (mode_q)
        MODE_ROT_L:  leds_d = (leds_q << 1) | (leds_q >> (LW - 1));
        MODE_ROT_R:  leds_d = (leds_q >> 1) | (leds_q << (LW - 1));
        MODE_BOUNCE: begin
          // End bit is shown for one step, then the direction reverses.
          if (LW > 1) begin
            if (dir_q == DIR_LEFT) begin
              if (leds_q[LW-1]) begin
                leds_d = leds_q >> 1;
                dir_d  = DIR_RIGHT;
              end else begin
                leds_d = leds_q << 1;
              end
            end else begin
              if (leds_q[0]) begin
                leds_d = leds_q << 1;
                dir_d  = DIR_LEFT;
              end else begin
                leds_d = leds_q >> 1;
              end
            end
          end
        end
        MODE_COUNT:  leds_d = leds_q + LW'(1);
        default:     leds_d = leds_q;
      endcase
    end
  end

  always_ff @(posedge clk100m or posedge rst) begin
    if (rst) begin
      leds_q <= LW'(SEED_PATTERN);
      tick_q <= 1'b0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_ROT_L;
    end else begin
      leds_q <= leds_d;
      tick_q <= tick_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected (leds, cycle) pairs are queued per tick.
module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned T = 4;

  typedef struct {
    logic [N-1:0] leds;
    int           cyc;
  } exp_t;

  logic clk100m = 1'b0;
  logic rst     = 1'b0;
  logic rst1    = 1'b0;

  always #5 clk100m = ~clk100m;

  led_sequencer_if #(.NUM_LEDS(N)) bus ();
  led_sequencer_if #(.NUM_LEDS(1)) bus1 ();

  led_sequencer #(.NUM_LEDS(N), .TICKS_PER_STEP(T)) dut (
    .clk100m (clk100m),
    .rst     (rst),
    .bus     (bus)
  );

  led_sequencer #(.NUM_LEDS(1), .TICKS_PER_STEP(1)) dut1 (
    .clk100m (clk100m),
    .rst     (rst1),
    .bus     (bus1)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ticks  = 0;

  always @(posedge clk100m) cyc <= cyc + 1;

  // Every observed tick must match the oldest queued expectation in value and cycle.
  always @(negedge clk100m) begin
    if (bus.tick === 1'b1) begin
      exp_t e;
      ticks++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cycle %0d leds %b, no tick expected", cyc, bus.leds);
      end else begin
        e = sb.pop_front();
        if (bus.leds !== e.leds || cyc != e.cyc) begin
          errors++;
          $display("FAIL tick_value: got leds %b at cycle %0d, expected %b at cycle %0d",
                   bus.leds, cyc, e.leds, e.cyc);
        end
      end
    end
  end

  task automatic push(input logic [N-1:0] l, input int c);
    exp_t e;
    e.leds = l;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic en);
    @(negedge clk100m);
    rst = 1'b1;
    bus.ctrl.mode   = m;
    bus.ctrl.enable = en;
    bus.ctrl.step   = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk100m);
    rst = 1'b0;
  endtask

  task automatic end_check(input string name);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missed: %0d expected ticks never seen, expected 0", name, sb.size());
    end
    sb.delete();
    rst = 1'b1;
    bus.ctrl.enable = 1'b0;
    bus.ctrl.step   = 1'b0;
  endtask

  task automatic test_reset();
    bus.ctrl  = '0;
    bus1.ctrl = '0;
    #1;
    rst  = 1'b1;
    rst1 = 1'b1;
    #1;
    checks++;
    if (bus.leds !== 4'b0001) begin
      errors++;
      $display("FAIL reset_leds: got %b, expected 0001", bus.leds);
    end
    checks++;
    if (bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_tick: got %b, expected 0", bus.tick);
    end
    checks++;
    if (bus1.leds !== 1'b1) begin
      errors++;
      $display("FAIL reset_leds_n1: got %b, expected 1", bus1.leds);
    end
  endtask

  task automatic test_rotate();
    int c0;
    int t0;
    do_reset(MODE_ROT_L, 1'b1);
    c0 = cyc;
    t0 = ticks;
    push(4'b0010, c0 + 4);
    push(4'b0100, c0 + 8);
    push(4'b1000, c0 + 12);
    push(4'b0001, c0 + 16);
    push(4'b0010, c0 + 20);
    repeat (20) @(negedge clk100m);
    #1;
    checks++;
    if (ticks - t0 != 5) begin
      errors++;
      $display("FAIL rotate_tick_count: got %0d, expected 5", ticks - t0);
    end
    end_check("rotate");
  endtask

  task automatic test_bounce();
    int c0;
    logic [N-1:0] seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    do_reset(MODE_BOUNCE, 1'b1);
    c0 = cyc;
    for (int k = 0; k < 7; k++) push(seq[k], c0 + 5 + 4 * k);
    @(negedge clk100m);
    checks++;
    if (bus.leds !== 4'b0001) begin
      errors++;
      $display("FAIL bounce_seed: got %b, expected 0001", bus.leds);
    end
    repeat (28) @(negedge clk100m);
    end_check("bounce");
  endtask

  task automatic test_count();
    int c0;
    do_reset(MODE_COUNT, 1'b1);
    c0 = cyc;
    for (int k = 1; k <= 16; k++) push(N'(k), c0 + 1 + 4 * k);
    @(negedge clk100m);
    checks++;
    if (bus.leds !== 4'b0000) begin
      errors++;
      $display("FAIL count_seed: got %b, expected 0000", bus.leds);
    end
    repeat (64) @(negedge clk100m);
    end_check("count");
  endtask

  task automatic test_pause();
    int c0;
    int t0;
    do_reset(MODE_ROT_L, 1'b1);
    c0 = cyc;
    repeat (2) @(negedge clk100m);
    bus.ctrl.enable = 1'b0;
    t0 = ticks;
    repeat (10) @(negedge clk100m);
    checks++;
    if (ticks != t0 || bus.leds !== 4'b0001) begin
      errors++;
      $display("FAIL pause_hold: got %0d ticks leds %b, expected 0 ticks leds 0001",
               ticks - t0, bus.leds);
    end
    bus.ctrl.enable = 1'b1;
    push(4'b0010, c0 + 14);
    repeat (2) @(negedge clk100m);
    end_check("pause");
  endtask

  task automatic test_step();
    int c0;
    do_reset(MODE_ROT_R, 1'b0);
    c0 = cyc;
    @(negedge clk100m);
    checks++;
    if (bus.leds !== 4'b0001) begin
      errors++;
      $display("FAIL step_seed: got %b, expected 0001", bus.leds);
    end
    bus.ctrl.step = 1'b1;
    push(4'b1000, c0 + 2);
    push(4'b0100, c0 + 3);
    push(4'b0010, c0 + 4);
    repeat (3) @(negedge clk100m);
    bus.ctrl.enable = 1'b1;
    push(4'b0001, c0 + 8);
    repeat (5) @(negedge clk100m);
    end_check("step");
  endtask

  task automatic test_mode_switch();
    int c0;
    int c1;
    do_reset(MODE_ROT_L, 1'b1);
    c0 = cyc;
    push(4'b0010, c0 + 4);
    repeat (7) @(negedge clk100m);
    bus.ctrl.mode = MODE_COUNT;
    @(negedge clk100m);
    checks++;
    if (bus.leds !== 4'b0000 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL mode_switch: got leds %b tick %b, expected leds 0000 tick 0",
               bus.leds, bus.tick);
    end
    push(4'b0001, c0 + 12);
    push(4'b0010, c0 + 16);
    repeat (10) @(negedge clk100m);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.leds !== 4'b0001 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got leds %b tick %b, expected leds 0001 tick 0",
               bus.leds, bus.tick);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mode_switch_missed: %0d expected ticks never seen, expected 0", sb.size());
    end
    sb.delete();
    bus.ctrl.mode = MODE_ROT_L;
    @(negedge clk100m);
    rst = 1'b0;
    c1 = cyc;
    push(4'b0010, c1 + 4);
    repeat (4) @(negedge clk100m);
    end_check("restart");
  endtask

  task automatic test_single_led();
    logic [1:0] mseq [10] = '{MODE_ROT_L, MODE_ROT_L, MODE_ROT_R, MODE_ROT_R, MODE_BOUNCE,
                              MODE_BOUNCE, MODE_BOUNCE, MODE_COUNT, MODE_COUNT, MODE_COUNT};
    logic       lseq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tseq [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk100m);
    rst1 = 1'b1;
    bus1.ctrl.mode   = MODE_ROT_L;
    bus1.ctrl.enable = 1'b1;
    bus1.ctrl.step   = 1'b0;
    @(negedge clk100m);
    rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus1.ctrl.mode = mseq[i];
      @(negedge clk100m);
      checks++;
      if (bus1.leds !== lseq[i] || bus1.tick !== tseq[i]) begin
        errors++;
        $display("FAIL single_led[%0d]: got leds %b tick %b, expected leds %b tick %b",
                 i, bus1.leds, bus1.tick, lseq[i], tseq[i]);
      end
    end
    rst1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_bounce();
    test_count();
    test_pause();
    test_step();
    test_mode_switch();
    test_single_led();
    repeat (2) @(negedge clk100m);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
